// File: rtl/sseg_to_bcd_scanner.sv
// Seven-segment display bus monitor: debounces each multiplexed digit dwell,
// decodes the lit segments back to BCD and publishes one frame per full scan.
module sseg_to_bcd_scanner #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          sseg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                valid,
  output logic [NDIG-1:0]     digit_err,
  output logic                pat_err
);

  localparam int            CW      = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 1);

  logic [6:0]            samp_seg, prev_seg;
  logic [NDIG-1:0]       samp_an, prev_an;
  logic [CW-1:0]         cnt;
  logic                  done;
  logic [NDIG-1:0]       seen;
  logic [NDIG-1:0][3:0]  slot;
  logic [NDIG-1:0]       werr;
  logic                  frame_done;

  logic                  same;
  logic                  an_onehot;
  logic                  reach;
  logic                  commit;
  logic [4:0]            dec;
  logic [NDIG-1:0]       seen_next;

  // Returns {error, nibble}; anything outside the ten digit glyphs is an error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  // The registered sample is compared with the one before it, so a dwell that
  // starts before edge E0 reaches the full count at edge E0+STABLE_CYC.
  always_comb begin
    same      = (samp_seg == prev_seg) && (samp_an == prev_an);
    an_onehot = (samp_an != '0) && ((samp_an & (samp_an - 1'b1)) == '0);
    reach     = same && (cnt == CNT_PRE);
    commit    = reach && !done && an_onehot;
    dec       = decode_seg(samp_seg);
    seen_next = seen | (commit ? samp_an : '0);
  end

  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values; the working slots are reset too, so a frame can
  // never expose stale data from before reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_seg   <= '0;
      prev_seg   <= '0;
      samp_an    <= '0;
      prev_an    <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      seen       <= '0;
      slot       <= '0;
      werr       <= '0;
      frame_done <= 1'b0;
      bcd_out    <= '0;
      valid      <= 1'b0;
      digit_err  <= '0;
      pat_err    <= 1'b0;
    end else begin
      samp_seg <= sseg;
      samp_an  <= an;
      prev_seg <= samp_seg;
      prev_an  <= samp_an;
      valid    <= 1'b0;

      if (!same) begin
        cnt  <= CW'(1);
        done <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (reach)          done <= 1'b1;
      end

      if (commit) begin
        for (int i = 0; i < NDIG; i++) begin
          if (samp_an[i]) begin
            slot[i] <= dec[3:0];
            werr[i] <= dec[4];
          end
        end
        if (&seen_next) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end

      // Publication lags completion by one edge; spacing between commits
      // guarantees this never coincides with another completion.
      if (frame_done) begin
        bcd_out    <= slot;
        digit_err  <= werr;
        pat_err    <= |werr;
        valid      <= 1'b1;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_to_bcd_scanner.sv
// Scoreboard bench for sseg_to_bcd_scanner: a behavioural digit model pushes
// expected frames when a completing dwell is driven; a monitor pops on valid.
module tb_sseg_to_bcd_scanner;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [6:0]         sseg = '0;
  logic [NDIG-1:0]    an = '0;
  logic [4*NDIG-1:0]  bcd_out;
  logic               valid;
  logic [NDIG-1:0]    digit_err;
  logic               pat_err;

  sseg_to_bcd_scanner #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .sseg      (sseg),
    .an        (an),
    .bcd_out   (bcd_out),
    .valid     (valid),
    .digit_err (digit_err),
    .pat_err   (pat_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  derr;
    logic        perr;
  } frame_t;

  frame_t       exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           valid_cnt = 0;
  int           push_cnt  = 0;
  logic         prev_valid = 1'b0;

  logic [6:0]   seg_tab[10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011};
  logic [3:0]   m_slot[NDIG];
  logic [NDIG-1:0] m_err;
  logic [NDIG-1:0] m_seen;
  frame_t       m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        if (prev_valid) check("valid_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(f.bcd));
          check("digit_err", 32'(digit_err), 32'(f.derr));
          check("pat_err", 32'(pat_err), 32'(f.perr));
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NDIG; i++) m_slot[i] = 4'h0;
    m_err  = '0;
    m_seen = '0;
  endfunction

  // Behavioural digit model: one commit per sufficiently long one-hot dwell.
  function automatic void model_commit(input logic [NDIG-1:0] a, input logic [6:0] s);
    int     d;
    frame_t f;
    d = -1;
    for (int k = 0; k < 10; k++) if (seg_tab[k] == s) d = k;
    for (int i = 0; i < NDIG; i++) begin
      if (a[i]) begin
        m_slot[i] = (d < 0) ? 4'hF : 4'(d);
        m_err[i]  = (d < 0);
      end
    end
    m_seen |= a;
    if (&m_seen) begin
      m_seen = '0;
      f.bcd  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      f.derr = m_err;
      f.perr = |m_err;
      exp_q.push_back(f);
      push_cnt++;
      m_last = f;
    end
  endfunction

  // Call just after a rising edge; holds the inputs for cyc rising edges.
  task automatic dwell(input logic [NDIG-1:0] a, input logic [6:0] s, input int cyc);
    an   = a;
    sseg = s;
    if (cyc >= STABLE && a != '0 && (a & (a - 1'b1)) == '0) model_commit(a, s);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    int vc;
    model_reset();
    m_last = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_pat_err", 32'(pat_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Scan 2025 with exact valid timing on the last dwell.
    dwell(4'b0001, 7'b1011011, 4);
    dwell(4'b0010, 7'b1101101, 4);
    dwell(4'b0100, 7'b1111110, 4);
    dwell(4'b1000, 7'b1101101, 4);
    an = '0;
    sseg = '0;
    @(posedge clk); #1;
    check("scan_valid_early", 32'(valid), 32'h0);
    @(posedge clk); #1;
    check("scan_valid_edge5", 32'(valid), 32'h1);
    check("scan_model_frame", 32'(m_last.bcd), 32'h2025);
    dwell('0, '0, 6);

    // Glitch: a 3-cycle dwell on digit 0 must not commit.
    vc = valid_cnt;
    dwell(4'b0001, 7'b0110000, 3);
    dwell(4'b0010, 7'b1111001, 4);
    dwell(4'b0100, 7'b0110011, 4);
    dwell(4'b1000, 7'b1110000, 4);
    dwell('0, '0, 10);
    check("glitch_no_valid", 32'(valid_cnt), 32'(vc));
    dwell(4'b0001, 7'b0110000, 4);
    dwell('0, '0, 8);
    check("glitch_frame_done", 32'(valid_cnt), 32'(vc + 1));

    // Invalid pattern on digit 2, then recovery.
    dwell(4'b0001, 7'b1011011, 4);
    dwell(4'b0010, 7'b1101101, 4);
    dwell(4'b0100, 7'b0000001, 4);
    dwell(4'b1000, 7'b1101101, 4);
    dwell('0, '0, 8);
    check("inv_bcd_out", 32'(bcd_out), 32'h2F25);
    check("inv_digit_err", 32'(digit_err), 32'h4);
    dwell(4'b0100, 7'b1111110, 4);
    dwell(4'b0001, 7'b1011011, 4);
    dwell(4'b1000, 7'b1101101, 4);
    dwell(4'b0010, 7'b1101101, 4);
    dwell('0, '0, 8);
    check("recover_pat_err", 32'(pat_err), 32'h0);

    // Bad selects: no commits, outputs hold.
    vc = valid_cnt;
    dwell(4'b0000, 7'b1111111, 10);
    dwell(4'b0011, 7'b1111111, 10);
    dwell('0, '0, 8);
    check("badsel_no_valid", 32'(valid_cnt), 32'(vc));
    check("badsel_hold_bcd", 32'(bcd_out), 32'(m_last.bcd));

    // Asynchronous reset mid-frame discards partial progress.
    dwell(4'b0001, 7'b1011111, 4);
    dwell(4'b0010, 7'b1111011, 4);
    dwell('0, '0, 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bcd_out", 32'(bcd_out), 32'h0);
    check("arst_digit_err", 32'(digit_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vc = valid_cnt;
    dwell(4'b0100, 7'b0110011, 4);
    dwell(4'b1000, 7'b0110000, 4);
    dwell('0, '0, 10);
    check("arst_partial_no_valid", 32'(valid_cnt), 32'(vc));
    dwell(4'b0001, 7'b1111001, 4);
    dwell(4'b0010, 7'b1110000, 4);
    dwell('0, '0, 8);
    check("arst_full_frame", 32'(valid_cnt), 32'(vc + 1));

    // Loopback: every BCD value on every digit, one frame per scan.
    vc = valid_cnt;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NDIG; i++) begin
        dwell(4'(1 << i), seg_tab[(f + i) % 10], 4);
      end
    end
    dwell('0, '0, 10);
    check("loop_frames", 32'(valid_cnt), 32'(vc + 10));

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("total_frames", 32'(valid_cnt), 32'(push_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
